cfg_chain_loader: RTL and testbench

//  Upstream configuration feeder for the connection-block (CB) programming chain.

---
 rtl/cfg_chain_loader.sv | 138 +++++++++++++
 tb/tb_cfg_chain_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// Byte-to-serial feeder for the connection-block configuration chain: shifts the
// bitstream LSB-first, then sends a commit token down the chain and waits for its return.
module cfg_chain_loader #(
  parameter int CB_BITS   = 48,
  parameter int NUM_CB    = 4,
  parameter int TOKEN_TMO = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       bit_in_CB,
  output logic       prgm_b,
  output logic       cb_prgm_b,
  output logic       cb_prgm_b_in,
  input  logic       cb_prgm_b_out,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state_dbg
);

  localparam int TOTAL = CB_BITS * NUM_CB;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int TW    = $clog2(TOKEN_TMO + 1);

  if (TOTAL == 0) begin : g_bad_total
    $error("cfg_chain_loader: CB_BITS*NUM_CB must be nonzero");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_TOKEN = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  // Handshake: in_data is taken on any rising edge where in_valid && in_ready;
  // in_ready depends only on state, so it never combinationally follows in_valid.
  logic [2:0]    state_q, state_d;
  logic [6:0]    sh_q, sh_d;
  logic          bit_q, bit_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] sent_q, sent_d;
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    sent_d  = sent_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          sent_d  = '0;
        end
      end
      S_LOAD: begin
        if (cb_prgm_b_out) begin
          state_d = S_ERR;
        end else if (in_valid) begin
          bit_d   = in_data[0];
          sh_d    = in_data[7:1];
          idx_d   = 3'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cb_prgm_b_out) begin
          state_d = S_ERR;
        end else begin
          sent_d = sent_q + 1'b1;
          // Final bit of the stream may fall mid-byte; the remaining bits are dropped.
          if (sent_q == CW'(TOTAL - 1)) begin
            state_d = S_TOKEN;
          end else if (idx_q == 3'd7) begin
            state_d = S_LOAD;
          end else begin
            bit_d = sh_q[0];
            sh_d  = {1'b0, sh_q[6:1]};
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_TOKEN: begin
        tmo_d   = '0;
        state_d = cb_prgm_b_out ? S_ERR : S_WAIT;
      end
      S_WAIT: begin
        if (cb_prgm_b_out) begin
          state_d = S_DONE;
        end else if (tmo_q == TW'(TOKEN_TMO - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bit_q   <= 1'b0;
      idx_q   <= '0;
      sent_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      sent_q  <= sent_d;
      tmo_q   <= tmo_d;
    end
  end

  // bit_q only changes when a new bit is presented, so it holds through input stalls.
  assign bit_in_CB    = bit_q;
  assign in_ready     = (state_q == S_LOAD);
  assign cb_prgm_b    = (state_q == S_SHIFT);
  assign cb_prgm_b_in = (state_q == S_TOKEN);
  assign prgm_b       = (state_q == S_LOAD) || (state_q == S_SHIFT) ||
                        (state_q == S_TOKEN) || (state_q == S_WAIT);
  assign busy         = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_WAIT);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: three parameterisations share stimulus, a select picks
// which one is driven and observed; shifted bits are scored against an expected queue.
module tb_cfg_chain_loader;

  localparam int TMO_B = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] sel;
  int         tok_mode;  // 0 loopback, 1 never returns, 2 forced high

  logic [2:0] in_ready_w, bit_w, prgm_w, cbp_w, cbin_w, cbout_w, busy_w, done_w, err_w, start_w;
  logic [2:0] loop_q;
  logic [2:0] state_w [3];

  logic m_in_ready, m_bit, m_prgm_b, m_cb_prgm_b, m_cb_in, m_busy, m_done, m_error;
  logic [2:0] m_state;

  logic [0:0] exp_q [$];
  logic [7:0] stim_q [$];
  int totals [3] = '{48, 12, 192};
  int vectors = 0;
  int miss = 0;
  int pushed, shift_cnt, tok_cnt;
  logic have_last, last_bit;

  always #5 clk = ~clk;

  cfg_chain_loader #(.CB_BITS(48), .NUM_CB(1)) u_a (
    .clk(clk), .reset(reset), .start(start_w[0]), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w[0]), .bit_in_CB(bit_w[0]), .prgm_b(prgm_w[0]), .cb_prgm_b(cbp_w[0]),
    .cb_prgm_b_in(cbin_w[0]), .cb_prgm_b_out(cbout_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .error(err_w[0]), .state_dbg(state_w[0]));

  cfg_chain_loader #(.CB_BITS(12), .NUM_CB(1), .TOKEN_TMO(TMO_B)) u_b (
    .clk(clk), .reset(reset), .start(start_w[1]), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w[1]), .bit_in_CB(bit_w[1]), .prgm_b(prgm_w[1]), .cb_prgm_b(cbp_w[1]),
    .cb_prgm_b_in(cbin_w[1]), .cb_prgm_b_out(cbout_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .error(err_w[1]), .state_dbg(state_w[1]));

  cfg_chain_loader u_c (
    .clk(clk), .reset(reset), .start(start_w[2]), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w[2]), .bit_in_CB(bit_w[2]), .prgm_b(prgm_w[2]), .cb_prgm_b(cbp_w[2]),
    .cb_prgm_b_in(cbin_w[2]), .cb_prgm_b_out(cbout_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .error(err_w[2]), .state_dbg(state_w[2]));

  // One-cycle chain model: the token emerges from the last CB one cycle after entering.
  always @(posedge clk or posedge reset) begin
    if (reset) loop_q <= '0;
    else       loop_q <= cbin_w;
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      start_w[i] = start && (sel == 2'(i));
      cbout_w[i] = (sel == 2'(i) && tok_mode != 0) ? (tok_mode == 2) : loop_q[i];
    end
    m_in_ready  = in_ready_w[sel];
    m_bit       = bit_w[sel];
    m_prgm_b    = prgm_w[sel];
    m_cb_prgm_b = cbp_w[sel];
    m_cb_in     = cbin_w[sel];
    m_busy      = busy_w[sel];
    m_done      = done_w[sel];
    m_error     = err_w[sel];
    m_state     = state_w[sel];
  end

  // Scoreboard side: pop one expected bit per shift-enable cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_cb_prgm_b) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miss++;
          $display("FAIL extra_shift: got bit %0b, expected no shift (bit %0d)", m_bit, shift_cnt);
        end else begin
          logic [0:0] e;
          e = exp_q.pop_front();
          if (m_bit !== e[0]) begin
            miss++;
            $display("FAIL shift_bit[%0d]: got %0b, expected %0b", shift_cnt, m_bit, e[0]);
          end
        end
        shift_cnt++;
        last_bit  = m_bit;
        have_last = 1'b1;
      end else if (m_in_ready && have_last) begin
        vectors++;
        if (m_bit !== last_bit) begin
          miss++;
          $display("FAIL stall_hold: bit_in_CB %0b, expected held %0b", m_bit, last_bit);
        end
      end
      if (m_cb_in) begin
        tok_cnt++;
        vectors++;
        if (m_cb_prgm_b !== 1'b0) begin
          miss++;
          $display("FAIL token_shift: cb_prgm_b %0b during token, expected 0", m_cb_prgm_b);
        end
      end
    end
  end

  task automatic begin_session(input logic [1:0] s);
    sel       = s;
    pushed    = 0;
    shift_cnt = 0;
    tok_cnt   = 0;
    have_last = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n, nb;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!m_in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!m_in_ready) begin
      vectors++;
      miss++;
      $display("FAIL in_ready_timeout: in_ready 0 after %0d cycles, expected 1", n);
    end else begin
      nb = totals[sel] - pushed;
      if (nb > 8) nb = 8;
      for (int i = 0; i < nb; i++) exp_q.push_back(b[i]);
      pushed += nb;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic send_stim(input int max_gap);
    foreach (stim_q[i]) send_byte(stim_q[i], $urandom_range(0, max_gap));
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(m_done || m_error) && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; tok_mode = 0; sel = 2'd0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      vectors++;
      if ({m_in_ready, m_bit, m_prgm_b, m_cb_prgm_b, m_cb_in, m_busy, m_done, m_error, m_state} !== 11'd0) begin
        miss++;
        $display("FAIL reset_outputs[%0d]: got %b, expected all zero", s,
                 {m_in_ready, m_bit, m_prgm_b, m_cb_prgm_b, m_cb_in, m_busy, m_done, m_error, m_state});
      end
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_full_byte_load();
    begin_session(2'd0);
    stim_q = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
    pulse_start();
    send_stim(0);
    wait_end();
    vectors += 4;
    if (m_done !== 1'b1 || m_error !== 1'b0) begin miss++; $display("FAIL t1_status: done %0b error %0b, expected 1 0", m_done, m_error); end
    if (m_prgm_b !== 1'b0) begin miss++; $display("FAIL t1_prgm_b: got %0b, expected 0", m_prgm_b); end
    if (shift_cnt != 48) begin miss++; $display("FAIL t1_bit_count: got %0d, expected 48", shift_cnt); end
    if (tok_cnt != 1) begin miss++; $display("FAIL t1_tokens: got %0d, expected 1", tok_cnt); end
  endtask

  task automatic test_partial_byte();
    begin_session(2'd1);
    stim_q = '{8'hFF, 8'hF3};
    pulse_start();
    send_stim(0);
    wait_end();
    vectors += 4;
    if (shift_cnt != 12) begin miss++; $display("FAIL t2_bit_count: got %0d, expected 12", shift_cnt); end
    if (exp_q.size() != 0) begin miss++; $display("FAIL t2_leftover: %0d bits unshifted, expected 0", exp_q.size()); end
    if (tok_cnt != 1) begin miss++; $display("FAIL t2_tokens: got %0d, expected 1", tok_cnt); end
    if (m_done !== 1'b1) begin miss++; $display("FAIL t2_done: got %0b, expected 1", m_done); end
  endtask

  task automatic test_gapped_stream();
    begin_session(2'd2);
    stim_q.delete();
    for (int i = 0; i < 24; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    pulse_start();
    send_stim(3);
    wait_end();
    vectors += 3;
    if (shift_cnt != 192) begin miss++; $display("FAIL t3_bit_count: got %0d, expected 192", shift_cnt); end
    if (m_done !== 1'b1 || m_error !== 1'b0) begin miss++; $display("FAIL t3_status: done %0b error %0b, expected 1 0", m_done, m_error); end
    if (tok_cnt != 1) begin miss++; $display("FAIL t3_tokens: got %0d, expected 1", tok_cnt); end
  endtask

  task automatic test_token_timeout();
    int n;
    begin_session(2'd1);
    tok_mode = 1;
    stim_q = '{8'hFF, 8'hF3};
    pulse_start();
    send_stim(0);
    n = 0;
    while (!m_cb_in && n < 100) begin @(negedge clk); n++; end
    // Token cycle, then TOKEN_TMO waiting cycles; error shows on the edge after that.
    n = 0;
    do begin @(negedge clk); n++; end while (!m_error && n < 200);
    vectors += 3;
    if (n != TMO_B + 1) begin miss++; $display("FAIL t4_timeout: error after %0d cycles, expected %0d", n, TMO_B + 1); end
    if (m_done !== 1'b0) begin miss++; $display("FAIL t4_done: got %0b, expected 0", m_done); end
    if (m_prgm_b !== 1'b0) begin miss++; $display("FAIL t4_prgm_b: got %0b, expected 0", m_prgm_b); end
    tok_mode = 0;
    begin_session(2'd1);
    pulse_start();
    vectors += 2;
    if (m_error !== 1'b0) begin miss++; $display("FAIL t4_err_clear: got %0b, expected 0", m_error); end
    if (m_busy !== 1'b1) begin miss++; $display("FAIL t4_restart_busy: got %0b, expected 1", m_busy); end
    send_stim(0);
    wait_end();
    vectors++;
    if (m_done !== 1'b1 || shift_cnt != 12) begin miss++; $display("FAIL t4_reload: done %0b bits %0d, expected 1 12", m_done, shift_cnt); end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    begin_session(2'd2);
    pulse_start();
    send_byte(8'h5A, 0);
    send_byte(8'hC3, 0);
    send_byte(8'h96, 0);
    n = 0;
    while (shift_cnt < 20 && n < 50) begin @(negedge clk); n++; end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({m_in_ready, m_bit, m_prgm_b, m_cb_prgm_b, m_cb_in, m_busy, m_done, m_error} !== 8'd0) begin
      miss++;
      $display("FAIL t5_async_reset: got %b, expected all zero",
               {m_in_ready, m_bit, m_prgm_b, m_cb_prgm_b, m_cb_in, m_busy, m_done, m_error});
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (m_state !== 3'd0 || m_busy !== 1'b0) begin miss++; $display("FAIL t5_idle: state %0d busy %0b, expected 0 0", m_state, m_busy); end
    begin_session(2'd2);
    stim_q.delete();
    for (int i = 0; i < 24; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    pulse_start();
    send_stim(1);
    wait_end();
    vectors++;
    if (m_done !== 1'b1 || shift_cnt != 192) begin miss++; $display("FAIL t5_reload: done %0b bits %0d, expected 1 192", m_done, shift_cnt); end
  endtask

  task automatic test_start_ignored_and_early_token();
    begin_session(2'd0);
    stim_q = '{8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
    pulse_start();
    send_byte(8'hA5, 0);
    vectors++;
    if (m_cb_prgm_b !== 1'b1) begin miss++; $display("FAIL t6_in_shift: cb_prgm_b %0b, expected 1", m_cb_prgm_b); end
    pulse_start();
    send_stim(0);
    wait_end();
    vectors++;
    if (m_done !== 1'b1 || shift_cnt != 48) begin miss++; $display("FAIL t6_no_restart: done %0b bits %0d, expected 1 48", m_done, shift_cnt); end
    begin_session(2'd0);
    pulse_start();
    vectors++;
    if (m_in_ready !== 1'b1) begin miss++; $display("FAIL t6_in_load: in_ready %0b, expected 1", m_in_ready); end
    tok_mode = 2;
    @(negedge clk);
    vectors++;
    if (m_error !== 1'b1 || m_done !== 1'b0) begin miss++; $display("FAIL t6_early_token: error %0b done %0b, expected 1 0", m_error, m_done); end
    tok_mode = 0;
  endtask

  initial begin
    test_reset();
    test_full_byte_load();
    test_partial_byte();
    test_gapped_stream();
    test_token_timeout();
    test_reset_mid_shift();
    test_start_ignored_and_early_token();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
